// File: rtl/tree_node_pkg.sv
// rtl/tree_node_pkg.sv - shared types and helpers for the round-robin tree node
// Purpose: node FSM state type and the id-width helper used by tree_node_rr_mux.
// Ports: none (package).
package tree_node_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } node_state_e;

  // Width of a child index; a two-child node still needs one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with rotating start pointer
// Purpose: grant the first requester at or after ptr, wrapping N-1 -> 0.
// Ports:
//   req         in  N   request vector
//   ptr         in  IW  search start index (0..N-1)
//   grant       out N   one-hot grant (zero when no request)
//   grant_idx   out IW  binary index of the granted requester
//   grant_valid out 1   any request granted
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  // One extra bit so ptr + offset (at most 2N-2) never overflows before the wrap.
  logic [IW:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, ptr} + (IW+1)'(off);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!grant_valid && req[cand[IW-1:0]]) begin
        grant_valid             = 1'b1;
        grant_idx               = cand[IW-1:0];
        grant[cand[IW-1:0]]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tree_node_rr_mux.sv
// rtl/tree_node_rr_mux.sv - round-robin fan-in node merging child streams into one registered stream
// Purpose: arbitrate NUM_CHILDREN child streams round-robin (optionally holding the grant for a
//   whole packet) into a single register slice that also carries the source child index.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   child_valid  in  per-child beat valid
//   child_data   in  per-child payload, child i at [i*DATA_W +: DATA_W]
//   child_last   in  per-child end of packet (used only when PKT_MODE=1)
//   child_ready  out per-child accept, at most one bit high
//   out_valid, out_data, out_id, out_last  registered upstream beat
//   out_ready    in  upstream accept
module tree_node_rr_mux
  import tree_node_pkg::*;
#(
  parameter int NUM_CHILDREN = 5,
  parameter int DATA_W       = 32,
  parameter int PKT_MODE     = 0,
  parameter int ID_W         = id_width(NUM_CHILDREN)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CHILDREN-1:0]        child_valid,
  input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
  input  logic [NUM_CHILDREN-1:0]        child_last,
  output logic [NUM_CHILDREN-1:0]        child_ready,
  output logic                           out_valid,
  output logic [DATA_W-1:0]              out_data,
  output logic [ID_W-1:0]                out_id,
  output logic                           out_last,
  input  logic                           out_ready
);

  node_state_e state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   lock_id_q, lock_id_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic              out_last_q, out_last_d;

  logic                    locked;
  logic [NUM_CHILDREN-1:0] lock_mask;
  logic [NUM_CHILDREN-1:0] arb_req;
  logic [ID_W-1:0]         arb_ptr;
  logic [NUM_CHILDREN-1:0] grant;
  logic [ID_W-1:0]         grant_idx;
  logic                    grant_valid;
  logic                    load_en;
  logic                    accept;
  logic [DATA_W-1:0]       sel_data;
  logic                    sel_last;
  logic [ID_W-1:0]         next_ptr;

  // While locked, only the locked child may be granted; if it is not valid the node bubbles.
  assign locked    = (PKT_MODE != 0) && (state_q == LOCKED);
  assign lock_mask = NUM_CHILDREN'(1) << lock_id_q;
  assign arb_req   = locked ? (child_valid & lock_mask) : child_valid;
  assign arb_ptr   = locked ? lock_id_q : ptr_q;

  rr_arbiter #(
    .N  (NUM_CHILDREN),
    .IW (ID_W)
  ) u_arb (
    .req         (arb_req),
    .ptr         (arb_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign load_en     = !out_valid_q || out_ready;
  assign accept      = load_en && grant_valid;
  // Reset also masks ready so no child sees an accept while the node is held in reset.
  assign child_ready = (load_en && rst_n) ? grant : '0;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CHILDREN; i++) begin
      if (grant[i]) begin
        sel_data = child_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Without packet mode every beat is a complete packet.
  assign sel_last = (PKT_MODE != 0) ? |(grant & child_last) : 1'b1;
  assign next_ptr = (grant_idx == ID_W'(NUM_CHILDREN - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_id_d   = lock_id_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;

    if (load_en) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d = sel_data;
        out_id_d   = grant_idx;
        out_last_d = sel_last;
      end
    end

    if (accept) begin
      if (PKT_MODE == 0) begin
        ptr_d = next_ptr;
      end else begin
        // The pointer only moves when a packet completes, so a locked packet
        // does not cost the next child its turn.
        case (state_q)
          IDLE: begin
            if (sel_last) begin
              ptr_d = next_ptr;
            end else begin
              state_d   = LOCKED;
              lock_id_d = grant_idx;
            end
          end
          LOCKED: begin
            if (sel_last) begin
              state_d = IDLE;
              ptr_d   = next_ptr;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      lock_id_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_id_q   <= lock_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_tree_node_rr_mux.sv
// tb/tb_tree_node_rr_mux.sv - directed and scoreboard checks for tree_node_rr_mux
module tb_tree_node_rr_mux;

  logic        clk;
  logic        rst_n;

  // Instance a: PKT_MODE=0
  logic [4:0]   cv, clast, cready;
  logic [31:0]  cdata [5];
  logic [159:0] cbus;
  logic         ov, olast, ordy;
  logic [31:0]  od;
  logic [2:0]   oid;

  // Instance b: PKT_MODE=1
  logic [4:0]   p_cv, p_clast, p_cready;
  logic [31:0]  p_cdata [5];
  logic [159:0] p_cbus;
  logic         p_ov, p_olast, p_ordy;
  logic [31:0]  p_od;
  logic [2:0]   p_oid;

  int checks;
  int errors;

  always_comb begin
    cbus   = '0;
    p_cbus = '0;
    for (int i = 0; i < 5; i++) begin
      cbus[i*32 +: 32]   = cdata[i];
      p_cbus[i*32 +: 32] = p_cdata[i];
    end
  end

  tree_node_rr_mux #(.NUM_CHILDREN(5), .DATA_W(32), .PKT_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .child_valid(cv), .child_data(cbus), .child_last(clast),
    .child_ready(cready), .out_valid(ov), .out_data(od), .out_id(oid), .out_last(olast),
    .out_ready(ordy)
  );

  tree_node_rr_mux #(.NUM_CHILDREN(5), .DATA_W(32), .PKT_MODE(1)) dut_pkt (
    .clk(clk), .rst_n(rst_n), .child_valid(p_cv), .child_data(p_cbus), .child_last(p_clast),
    .child_ready(p_cready), .out_valid(p_ov), .out_data(p_od), .out_id(p_oid), .out_last(p_olast),
    .out_ready(p_ordy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cv = 5'h1f; clast = '0; ordy = 1'b1;
    p_cv = 5'h1f; p_clast = '0; p_ordy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cdata[i]   = 32'h100 + i;
      p_cdata[i] = 32'h200 + i;
    end
    tick; tick;
    checks++;
    if (ov !== 1'b0 || od !== 32'h0 || oid !== 3'd0 || olast !== 1'b0 || cready !== 5'h0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%0h id=%0d l=%b rdy=%b want all 0", ov, od, oid, olast, cready);
    end
    checks++;
    if (p_ov !== 1'b0 || p_cready !== 5'h0 || p_olast !== 1'b0) begin
      errors++;
      $display("FAIL reset_pkt_outputs got v=%b rdy=%b l=%b want 0", p_ov, p_cready, p_olast);
    end
    p_cv = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin;
    logic [2:0] exp;
    cv = 5'h1f;
    for (int k = 0; k < 6; k++) begin
      exp = 3'(k % 5);
      #1;
      checks++;
      if (cready !== (5'b1 << exp)) begin
        errors++;
        $display("FAIL rr_ready beat %0d got %b want %b", k, cready, 5'b1 << exp);
      end
      tick;
      checks++;
      if (ov !== 1'b1 || oid !== exp || od !== 32'h100 + 32'(exp)) begin
        errors++;
        $display("FAIL rr_out beat %0d got v=%b id=%0d d=%0h want v=1 id=%0d d=%0h", k, ov, oid, od, exp, 32'h100 + 32'(exp));
      end
    end
    checks++;
    if (olast !== 1'b1) begin
      errors++;
      $display("FAIL rr_last got %b want 1", olast);
    end
  endtask

  task automatic test_backpressure;
    ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (cready !== 5'h0) begin
        errors++;
        $display("FAIL bp_ready cycle %0d got %b want 0", k, cready);
      end
      tick;
      checks++;
      if (ov !== 1'b1 || oid !== 3'd0 || od !== 32'h100) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%b id=%0d d=%0h want v=1 id=0 d=100", k, ov, oid, od);
      end
    end
    ordy = 1'b1;
    #1;
    checks++;
    if (cready !== 5'b00010) begin
      errors++;
      $display("FAIL bp_resume_ready got %b want 00010", cready);
    end
    tick;
    checks++;
    if (oid !== 3'd1 || od !== 32'h101) begin
      errors++;
      $display("FAIL bp_resume got id=%0d d=%0h want id=1 d=101", oid, od);
    end
  endtask

  task automatic test_sparse;
    cv = 5'b10000;
    #1;
    checks++;
    if (cready !== 5'b10000) begin
      errors++;
      $display("FAIL sparse_ready4 got %b want 10000", cready);
    end
    tick;
    checks++;
    if (ov !== 1'b1 || oid !== 3'd4 || od !== 32'h104) begin
      errors++;
      $display("FAIL sparse_4 got v=%b id=%0d d=%0h want id=4 d=104", ov, oid, od);
    end
    cv = 5'b00010;
    tick;
    checks++;
    if (oid !== 3'd1 || od !== 32'h101) begin
      errors++;
      $display("FAIL sparse_1 got id=%0d d=%0h want id=1 d=101", oid, od);
    end
    cv = 5'h1f;
    tick;
    checks++;
    if (oid !== 3'd2) begin
      errors++;
      $display("FAIL sparse_ptr got id=%0d want 2", oid);
    end
    cv = 5'h0;
    tick;
    checks++;
    if (ov !== 1'b0) begin
      errors++;
      $display("FAIL idle_clear got v=%b want 0", ov);
    end
  endtask

  task automatic test_mid_reset;
    cv = 5'h1f;
    tick;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov !== 1'b0 || od !== 32'h0 || oid !== 3'd0 || olast !== 1'b0 || cready !== 5'h0) begin
      errors++;
      $display("FAIL midreset got v=%b d=%0h id=%0d l=%b rdy=%b want all 0", ov, od, oid, olast, cready);
    end
    tick;
    rst_n = 1'b1;
    #1;
    checks++;
    if (cready !== 5'b00001) begin
      errors++;
      $display("FAIL midreset_ready got %b want 00001", cready);
    end
    tick;
    checks++;
    if (ov !== 1'b1 || oid !== 3'd0) begin
      errors++;
      $display("FAIL midreset_first got v=%b id=%0d want v=1 id=0", ov, oid);
    end
    cv = 5'h0;
    tick;
  endtask

  task automatic test_packet_lock;
    p_ordy = 1'b1;
    p_cv = 5'b01100;
    p_cdata[2] = 32'h20; p_clast[2] = 1'b0;
    p_cdata[3] = 32'h30; p_clast[3] = 1'b1;
    #1;
    checks++;
    if (p_cready !== 5'b00100) begin
      errors++;
      $display("FAIL pkt_first_ready got %b want 00100", p_cready);
    end
    tick;
    checks++;
    if (p_ov !== 1'b1 || p_oid !== 3'd2 || p_od !== 32'h20 || p_olast !== 1'b0) begin
      errors++;
      $display("FAIL pkt_beat1 got v=%b id=%0d d=%0h l=%b want 1 2 20 0", p_ov, p_oid, p_od, p_olast);
    end
    p_cv = 5'b01000;
    #1;
    checks++;
    if (p_cready !== 5'h0) begin
      errors++;
      $display("FAIL pkt_gap_ready got %b want 00000", p_cready);
    end
    tick;
    checks++;
    if (p_ov !== 1'b0) begin
      errors++;
      $display("FAIL pkt_gap_bubble got v=%b want 0", p_ov);
    end
    p_cv = 5'b01100; p_cdata[2] = 32'h21;
    tick;
    checks++;
    if (p_ov !== 1'b1 || p_oid !== 3'd2 || p_od !== 32'h21 || p_olast !== 1'b0) begin
      errors++;
      $display("FAIL pkt_beat2 got v=%b id=%0d d=%0h l=%b want 1 2 21 0", p_ov, p_oid, p_od, p_olast);
    end
    p_cdata[2] = 32'h22; p_clast[2] = 1'b1;
    #1;
    checks++;
    if (p_cready !== 5'b00100) begin
      errors++;
      $display("FAIL pkt_beat3_ready got %b want 00100", p_cready);
    end
    tick;
    checks++;
    if (p_oid !== 3'd2 || p_od !== 32'h22 || p_olast !== 1'b1) begin
      errors++;
      $display("FAIL pkt_beat3 got id=%0d d=%0h l=%b want 2 22 1", p_oid, p_od, p_olast);
    end
    p_cv = 5'b01000;
    tick;
    checks++;
    if (p_ov !== 1'b1 || p_oid !== 3'd3 || p_od !== 32'h30 || p_olast !== 1'b1) begin
      errors++;
      $display("FAIL pkt_child3 got v=%b id=%0d d=%0h l=%b want 1 3 30 1", p_ov, p_oid, p_od, p_olast);
    end
    p_cv = 5'b10100;
    p_cdata[4] = 32'h40; p_clast[4] = 1'b1;
    p_cdata[2] = 32'h23; p_clast[2] = 1'b1;
    tick;
    checks++;
    if (p_oid !== 3'd4 || p_od !== 32'h40) begin
      errors++;
      $display("FAIL pkt_single4 got id=%0d d=%0h want 4 40", p_oid, p_od);
    end
    tick;
    checks++;
    if (p_oid !== 3'd2 || p_od !== 32'h23) begin
      errors++;
      $display("FAIL pkt_after_single got id=%0d d=%0h want 2 23", p_oid, p_od);
    end
    p_cv = 5'h0;
    tick;
    checks++;
    if (p_ov !== 1'b0) begin
      errors++;
      $display("FAIL pkt_idle got v=%b want 0", p_ov);
    end
  endtask

  task automatic test_random;
    int sent [5];
    int rcv  [5];
    logic [4:0]  in_acc;
    logic [31:0] exp;
    bit gen;
    for (int c = 0; c < 5; c++) begin
      sent[c] = 0;
      rcv[c]  = 0;
      cdata[c] = {8'(c), 24'(0)};
    end
    cv = '0;
    ordy = 1'b1;
    for (int cyc = 0; cyc < 3020; cyc++) begin
      gen = (cyc < 3000);
      #1;
      in_acc = cv & cready;
      checks++;
      if ($countones(cready) > 1 || (cready & ~cv) != 5'h0) begin
        errors++;
        $display("FAIL rand_ready cycle %0d got rdy=%b valid=%b want onehot subset", cyc, cready, cv);
      end
      if (ov && ordy) begin
        checks++;
        if (oid > 3'd4) begin
          errors++;
          $display("FAIL rand_id cycle %0d got %0d want <5", cyc, oid);
        end else begin
          exp = {8'(oid), 24'(rcv[oid])};
          if (od !== exp) begin
            errors++;
            $display("FAIL rand_beat cycle %0d got %0h want %0h", cyc, od, exp);
          end
          rcv[oid]++;
        end
      end
      tick;
      for (int c = 0; c < 5; c++) begin
        if (in_acc[c]) sent[c]++;
        if (!cv[c] || in_acc[c]) begin
          cv[c]    = gen ? ($urandom_range(0, 2) != 0) : 1'b0;
          cdata[c] = {8'(c), 24'(sent[c])};
        end
      end
      ordy = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (sent[c] != rcv[c] || sent[c] == 0) begin
        errors++;
        $display("FAIL rand_count child %0d got out=%0d want in=%0d (nonzero)", c, rcv[c], sent[c]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_round_robin;
    test_backpressure;
    test_sparse;
    test_mid_reset;
    test_packet_lock;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
